// File: rtl/mp_add_pkg.sv
// Shared types for the multi-precision add sequencer: limb width default,
// sequencer FSM states and the registered result record.
package mp_add_pkg;

    localparam int LIMB_W_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [LIMB_W_DEF-1:0] sum;
        logic                  last;
        logic                  cout;
    } result_t;

endpackage

// File: rtl/mp_add_out_reg.sv
// One-entry output holding register for result limbs. It accepts a new
// limb whenever it is empty or being popped in the same cycle, so a
// continuously ready consumer sees one limb per cycle with no bubbles.
module mp_add_out_reg
    import mp_add_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  result_t d,
    input  logic    out_ready,
    output logic    out_valid,
    output result_t q,
    output logic    in_ready
);

    // Room for a new limb when empty or when the held one leaves this cycle.
    assign in_ready = !out_valid | out_ready;

    // Load on upstream fire, otherwise drop valid on pop; data held until replaced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            q         <= d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mp_add_sequencer.sv
// Streams multi-precision operands (LSB limb first) through an external
// combinational ripple adder, chaining the carry between limbs and
// presenting registered result limbs on a valid/ready stream.
// Optional build macro MP_ADD_SEQ_SUB_MODE_EN adds in_sub for A-B operations
// (operand B inverted, carry-in 1 on the first limb; out_cout=1 means no borrow).
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int LIMB_W    = LIMB_W_DEF,
    parameter int NUM_LIMBS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LIMB_W-1:0] in_a,
    input  logic [LIMB_W-1:0] in_b,
    input  logic              in_first,
    input  logic              in_last,
`ifdef MP_ADD_SEQ_SUB_MODE_EN
    input  logic              in_sub,
`endif
    output logic [LIMB_W-1:0] add_a,
    output logic [LIMB_W-1:0] add_b,
    output logic              add_cin,
    input  logic [LIMB_W-1:0] add_sum,
    input  logic              add_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LIMB_W-1:0] out_sum,
    output logic              out_last,
    output logic              out_cout,
    output logic              err
);

    localparam int               CNT_W = $clog2(NUM_LIMBS) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(NUM_LIMBS);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count_p0, count_nxt;
    logic             carry_p0;
    logic             err_p0, err_nxt;
    logic             fire, treat_first, is_last, sub_eff;
    result_t          res_d, res_q;

    assign fire  = in_valid & in_ready;
    assign add_a = in_a;

`ifdef MP_ADD_SEQ_SUB_MODE_EN
    logic sub_p0;

    // Operation mode is captured with the limb that starts an operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_p0 <= 1'b0;
        end else if (fire & treat_first) begin
            sub_p0 <= in_sub;
        end
    end

    assign sub_eff = treat_first ? in_sub : sub_p0;
`else
    assign sub_eff = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: any accepted limb either closes the operation or keeps it open.
    always_comb begin
        state_nxt = state;
        if (fire) begin
            state_nxt = is_last ? IDLE : BUSY;
        end
    end

    // Adder drive, limb classification and protocol-error detection.
    always_comb begin
        treat_first = (state == IDLE) | in_first;
        count_nxt   = treat_first ? CNT_W'(1) : count_p0 + CNT_W'(1);
        is_last     = in_last | (count_nxt == LIMIT);
        add_b       = sub_eff ? ~in_b : in_b;
        add_cin     = treat_first ? sub_eff : carry_p0;
        err_nxt     = fire & (((state == IDLE) & !in_first) |
                              ((state == BUSY) & in_first)  |
                              ((count_nxt == LIMIT) & !in_last));
        res_d.sum   = add_sum;
        res_d.last  = is_last;
        res_d.cout  = is_last & add_cout;
    end

    // Carry chain, limb count and registered error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_p0 <= 1'b0;
            count_p0 <= '0;
            err_p0   <= 1'b0;
        end else begin
            err_p0 <= err_nxt;
            if (fire) begin
                if (is_last) begin
                    carry_p0 <= 1'b0;
                    count_p0 <= '0;
                end else begin
                    carry_p0 <= add_cout;
                    count_p0 <= count_nxt;
                end
            end
        end
    end

    mp_add_out_reg u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (fire),
        .d         (res_d),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .q         (res_q),
        .in_ready  (in_ready)
    );

    assign out_sum  = res_q.sum;
    assign out_last = res_q.last;
    assign out_cout = res_q.cout;
    assign err      = err_p0;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Scoreboard bench for mp_add_sequencer: the driver feeds limbs and pushes
// expectations from a wide-integer reference model; a negedge monitor pops
// and compares result limbs and error pulses.
module tb_mp_add_sequencer;

    localparam int W = 16;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_first, in_last;
    logic [W-1:0] in_a, in_b;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_cin, add_cout;
    logic         out_valid, out_ready, out_last, out_cout, err;
    logic [W-1:0] out_sum;
`ifdef MP_ADD_SEQ_SUB_MODE_EN
    logic         in_sub;
`endif

    always #5 clk = ~clk;

    mp_add_sequencer #(.LIMB_W(W), .NUM_LIMBS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
`ifdef MP_ADD_SEQ_SUB_MODE_EN
        .in_sub    (in_sub),
`endif
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .err       (err)
    );

    // External 16-bit ripple adder stage
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};

    typedef struct {
        logic [W-1:0] sum;
        logic         last;
        logic         cout;
    } exp_t;

    exp_t out_q[$];
    logic err_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ready_mode = 0;

    // Reference model state: current operation as whole integers
    int           grp_len = 0;
    logic [79:0]  acc_a = '0, acc_b = '0;
    logic         grp_cin = 1'b0, grp_sub = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        grp_len = 0;
        acc_a   = '0;
        acc_b   = '0;
        grp_cin = 1'b0;
        grp_sub = 1'b0;
    endtask

    task automatic model_fire(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic first, input logic last, input logic sub,
                              output logic exp_cin, output logic [W-1:0] exp_b);
        logic [80:0] prev, total;
        logic        e_err;
        exp_t        e;
        logic        tf;
        tf    = (grp_len == 0) || first;
        e_err = (grp_len == 0 && !first) || (grp_len != 0 && first);
        if (tf) begin
            model_reset();
            grp_sub = sub;
            grp_cin = sub;
        end
        exp_b   = grp_sub ? ~b : b;
        prev    = {1'b0, acc_a} + {1'b0, acc_b} + 81'(grp_cin);
        exp_cin = prev[16*grp_len];
        acc_a   = acc_a | (80'(a) << (16*grp_len));
        acc_b   = acc_b | (80'(exp_b) << (16*grp_len));
        total   = {1'b0, acc_a} + {1'b0, acc_b} + 81'(grp_cin);
        e.sum   = total[16*grp_len +: 16];
        grp_len++;
        e.last  = last || (grp_len == N);
        if (grp_len == N && !last) e_err = 1'b1;
        e.cout  = e.last ? total[16*grp_len] : 1'b0;
        if (e.last) grp_len = 0;
        out_q.push_back(e);
        err_q.push_back(e_err);
    endtask

    // Called at posedge+1; returns at posedge+1 after the limb was accepted.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic first, input logic last, input logic sub);
        int           waitc = 0;
        bit           done  = 0;
        logic         ec;
        logic [W-1:0] eb;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_first = first;
        in_last  = last;
`ifdef MP_ADD_SEQ_SUB_MODE_EN
        in_sub   = sub;
`endif
        while (!done) begin
            #2;
            if (in_ready) begin
                model_fire(a, b, first, last, sub, ec, eb);
                chk("add_a", 32'(add_a), 32'(a));
                chk("add_b", 32'(add_b), 32'(eb));
                chk("add_cin", 32'(add_cin), 32'(ec));
                done = 1;
            end else begin
                waitc++;
                if (waitc > 100) begin
                    chk("in_ready_timeout", 0, 1);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Consumer readiness pattern
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    logic fire_d;
    always @(posedge clk or posedge rst) begin
        if (rst) fire_d <= 1'b0;
        else     fire_d <= in_valid & in_ready;
    end

    // Monitor: result limbs, hold stability and error pulses
    logic         hold_prev = 1'b0;
    logic [W-1:0] hold_sum;
    logic         hold_last, hold_cout;
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_sum", 32'(out_sum), 32'(hold_sum));
                chk("hold_last", 32'(out_last), 32'(hold_last));
                chk("hold_cout", 32'(out_cout), 32'(hold_cout));
            end
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = out_q.pop_front();
                    chk("out_sum", 32'(out_sum), 32'(e.sum));
                    chk("out_last", 32'(out_last), 32'(e.last));
                    chk("out_cout", 32'(out_cout), 32'(e.cout));
                end
            end
            hold_prev = out_valid && !out_ready;
            hold_sum  = out_sum;
            hold_last = out_last;
            hold_cout = out_cout;
            if (fire_d) begin
                if (err_q.size() == 0) chk("err_queue_empty", 1, 0);
                else                   chk("err", 32'(err), 32'(err_q.pop_front()));
            end else begin
                chk("err_idle", 32'(err), 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waitc;
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_first = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
`ifdef MP_ADD_SEQ_SUB_MODE_EN
        in_sub = 1'b0;
`endif
        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sum", 32'(out_sum), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_cout", 32'(out_cout), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single-limb add with carry out
        send(16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b0);
        idle(2);

        // 4-limb back-to-back add
        send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
        send(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        send(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        send(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Backpressure for 3 cycles mid-operation
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        send(16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0);
        ready_mode = 2;
        out_ready  = 1'b0;
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h4321; in_first = 1'b0; in_last = 1'b0;
        repeat (3) begin
            #2;
            chk("bp_in_ready", 32'(in_ready), 0);
            @(posedge clk); #1;
        end
        ready_mode = 0;
        out_ready  = 1'b1;
        send(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0);
        idle(2);

        // in_first during an open operation restarts it
        send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
        send(16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Five limbs without in_last: limit forces the 4th as last
        send(16'hAAAA, 16'h5556, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) send(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Asynchronous reset after 2 of 4 limbs
        send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_out_sum", 32'(out_sum), 0);
        out_q.delete();
        err_q.delete();
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        send(16'h8000, 16'h8001, 1'b1, 1'b1, 1'b0);
        idle(2);

`ifdef MP_ADD_SEQ_SUB_MODE_EN
        // Subtract 0x0001_0000 - 0x0000_0001
        send(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1);
        send(16'h0001, 16'h0000, 1'b0, 1'b1, 1'b1);
        idle(2);
`endif

        // Randomized operations with random backpressure and gaps
        ready_mode = 1;
        for (int op = 0; op < 120; op++) begin
            int   len;
            bit   legal;
            logic sub;
            len   = $urandom_range(1, N);
            legal = ($urandom_range(0, 4) != 0);
            sub   = 1'b0;
`ifdef MP_ADD_SEQ_SUB_MODE_EN
            sub   = 1'($urandom_range(0, 1));
`endif
            for (int k = 0; k < len; k++) begin
                logic f, l;
                if (legal) begin
                    f = (k == 0);
                    l = (k == len - 1);
                end else begin
                    f = ($urandom_range(0, 3) == 0);
                    l = ($urandom_range(0, 3) == 0);
                end
                send(16'($urandom), 16'($urandom), f, l, sub);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end

        // Drain
        ready_mode = 0;
        waitc = 0;
        while ((out_q.size() != 0 || err_q.size() != 0) && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        idle(2);
        chk("drain_out_q", 32'(out_q.size()), 0);
        chk("drain_err_q", 32'(err_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
